// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline ports, the memory arbiter and the single-port memory.
// The slave modport is the arbiter's view; the master modport is the environment's view
// (pipeline requesters plus the memory model).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch port
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_valid_o;
  logic              if_stall_o;
  // data port
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_valid_o;
  logic              dm_stall_o;
  logic              err_o;
  // memory side
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    output if_rdata_o, if_valid_o, if_stall_o, dm_rdata_o, dm_valid_o, dm_stall_o,
           err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    input  if_rdata_o, if_valid_o, if_stall_o, dm_rdata_o, dm_valid_o, dm_stall_o,
           err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the IF stage (read-only) and the MEM
// stage (read/write). Data has priority, bounded by a streak counter so IF cannot starve;
// a timeout counter aborts an access the memory never acknowledges.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int D_MAX  = 4,
  parameter int TO_CYC = 255,
  parameter int TO_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int STK_W = $clog2(D_MAX + 1);
  localparam logic [STK_W-1:0] D_MAX_C = STK_W'(D_MAX);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_D_ACC = 2'd1,
    ST_I_ACC = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e            state_q;
  logic [STK_W-1:0]  streak_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_valid_q;
  logic              dm_valid_q;
  logic              err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              data_win_s;

  // Data wins unless IF is waiting and data already used up its streak allowance.
  assign data_win_s = bus.dm_req_i & (~bus.if_req_i | (streak_q < D_MAX_C));

  // Arbitration FSM: grant in IDLE, hold the memory request in ACC, pulse valid in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      to_cnt_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_win_s) begin
            state_q     <= ST_D_ACC;
            streak_q    <= bus.if_req_i ? (streak_q + STK_W'(1)) : '0;
            to_cnt_q    <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we_i;
            mem_addr_q  <= bus.dm_addr_i;
            mem_wdata_q <= bus.dm_wdata_i;
          end else if (bus.if_req_i) begin
            state_q     <= ST_I_ACC;
            streak_q    <= '0;
            to_cnt_q    <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr_i;
            mem_wdata_q <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_D_ACC, ST_I_ACC: begin
          // An ack in the timeout cycle still counts as a normal completion.
          if (bus.mem_ack_i) begin
            state_q   <= ST_RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (state_q == ST_D_ACC) begin
              dm_valid_q <= 1'b1;
              dm_rdata_q <= mem_we_q ? '0 : bus.mem_rdata_i;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= bus.mem_rdata_i;
            end
          end else if (to_cnt_q == TO_LAST) begin
            state_q   <= ST_RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= 1'b1;
            if (state_q == ST_D_ACC) begin
              dm_valid_q <= 1'b1;
              dm_rdata_q <= '0;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= '0;
            end
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ST_RESP: begin
          state_q    <= ST_IDLE;
          if_valid_q <= 1'b0;
          dm_valid_q <= 1'b0;
          err_q      <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          mem_req_q  <= 1'b0;
          mem_we_q   <= 1'b0;
          if_valid_q <= 1'b0;
          dm_valid_q <= 1'b0;
          err_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_valid_o  = if_valid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_valid_o  = dm_valid_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.err_o       = err_q;

  // Stalls are combinational so the pipeline releases in the same cycle as the valid pulse.
  assign bus.if_stall_o  = bus.if_req_i & ~if_valid_q;
  assign bus.dm_stall_o  = bus.dm_req_i & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized rounds, all checked
// against a transaction-level reference of the arbitration and response rules.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int D_MAX  = 4;
  localparam int TO_CYC = 255;
  localparam int TO_W   = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: consecutive data grants made while IF was waiting.
  int          streak = 0;
  // Requester intent, applied to the bus by drive().
  logic        if_pend, dm_pend, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        won;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .D_MAX(D_MAX), .TO_CYC(TO_CYC), .TO_W(TO_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.if_req_i   = if_pend;
    bus.if_addr_i  = if_addr;
    bus.dm_req_i   = dm_pend;
    bus.dm_we_i    = dm_we;
    bus.dm_addr_i  = dm_addr;
    bus.dm_wdata_i = dm_wdata;
    #1;
  endtask

  // One complete access from IDLE: grant, 'delay' cycles without ack, then ack (or timeout
  // when 'to' is set), response cycle, and return to IDLE. obs_dm reports which port the
  // DUT actually answered.
  task automatic run_round(input int delay, input bit to, input bit drop,
                           input logic [31:0] rd, output logic obs_dm);
    logic        w_dm, e_we;
    logic [31:0] e_addr, e_wdata, e_rd;
    int          n;
    drive();
    if (dm_pend && (!if_pend || streak < D_MAX)) begin
      w_dm = 1'b1; streak = if_pend ? streak + 1 : 0;
      e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
    end else begin
      w_dm = 1'b0; streak = 0;
      e_we = 1'b0; e_addr = if_addr; e_wdata = 32'h0;
    end
    tick();
    check("grant_mem", 64'({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o}), 64'({1'b1, e_we, e_addr}));
    check("grant_novalid", 64'({bus.if_valid_o, bus.dm_valid_o, bus.err_o}), 64'(3'b000));
    check("grant_stall", 64'({bus.if_stall_o, bus.dm_stall_o}), 64'({if_pend, dm_pend}));
    if (w_dm) check("grant_wdata", 64'(bus.mem_wdata_o), 64'(e_wdata));
    n = to ? TO_CYC - 1 : delay;
    for (int i = 0; i < n; i++) begin
      bus.mem_rdata_i = $urandom;
      if (drop && i == 0) begin
        if (w_dm) dm_pend = 1'b0; else if_pend = 1'b0;
        drive();
      end
      tick();
      check("acc_stable", 64'({bus.mem_req_o, bus.mem_we_o, bus.if_valid_o, bus.dm_valid_o, bus.mem_addr_o}),
            64'({1'b1, e_we, 2'b00, e_addr}));
      if (w_dm) check("acc_wdata", 64'(bus.mem_wdata_o), 64'(e_wdata));
    end
    bus.mem_rdata_i = rd;
    bus.mem_ack_i   = !to;
    tick();
    bus.mem_ack_i   = 1'b0;
    e_rd = (to || (w_dm && e_we)) ? 32'h0 : rd;
    check("resp_valid", 64'({bus.if_valid_o, bus.dm_valid_o}), 64'({!w_dm, w_dm}));
    check("resp_err", 64'(bus.err_o), 64'(to));
    check("resp_memreq", 64'(bus.mem_req_o), 64'(1'b0));
    if (w_dm) check("resp_dm_rdata", 64'(bus.dm_rdata_o), 64'(e_rd));
    else      check("resp_if_rdata", 64'(bus.if_rdata_o), 64'(e_rd));
    check("resp_stall", 64'({bus.if_stall_o, bus.dm_stall_o}),
          64'({if_pend & w_dm, dm_pend & !w_dm}));
    obs_dm = bus.dm_valid_o;
    if (w_dm) dm_pend = 1'b0; else if_pend = 1'b0;
    drive();
    tick();
    check("idle_clear", 64'({bus.if_valid_o, bus.dm_valid_o, bus.err_o, bus.mem_req_o}), 64'(4'b0000));
  endtask

  initial begin
    if_pend = 1'b0; dm_pend = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 32'h0;
    rst_n = 1'b0;
    drive();
    tick(); tick(); tick();
    check("rst_outputs", 64'({bus.mem_req_o, bus.mem_we_o, bus.if_valid_o, bus.dm_valid_o, bus.err_o}), 64'(5'b00000));
    check("rst_addr", 64'(bus.mem_addr_o), 64'(32'h0));
    check("rst_rdata", 64'({bus.if_rdata_o, bus.dm_rdata_o}), 64'(0));
    rst_n = 1'b1;

    // Reset in the middle of a data access drops it without a valid pulse.
    dm_pend = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hA5A5A5A5;
    drive();
    tick();
    check("pre_rst_req", 64'(bus.mem_req_o), 64'(1'b1));
    rst_n = 1'b0;
    tick(); tick(); tick();
    check("mid_rst_req", 64'({bus.mem_req_o, bus.mem_we_o}), 64'(2'b00));
    dm_pend = 1'b0;
    drive();
    rst_n = 1'b1;
    streak = 0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack_i = 1'b1;
      tick();
      check("post_rst_quiet", 64'({bus.dm_valid_o, bus.if_valid_o, bus.mem_req_o}), 64'(3'b000));
    end
    bus.mem_ack_i = 1'b0;

    // IF read with immediate ack.
    if_pend = 1'b1; if_addr = 32'h100;
    run_round(0, 1'b0, 1'b0, 32'hDEADBEEF, won);

    // Simultaneous requests: data write first, IF afterwards.
    if_pend = 1'b1; if_addr = 32'h104;
    dm_pend = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h12345678;
    run_round(1, 1'b0, 1'b0, $urandom, won);
    check("t3_first_dm", 64'(won), 64'(1'b1));
    run_round(0, 1'b0, 1'b0, $urandom, won);
    check("t3_then_if", 64'(won), 64'(1'b0));

    // Continuous data pressure with IF waiting: four data grants then one IF grant.
    for (int i = 0; i < 10; i++) begin
      dm_pend = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = 32'h800 + 32'(i * 4); dm_wdata = $urandom;
      if (!if_pend) begin if_pend = 1'b1; if_addr = 32'h400 + 32'(i * 4); end
      run_round(0, 1'b0, 1'b0, $urandom, won);
      check("t4_pattern", 64'(won), 64'((i % 5) != 4));
    end
    dm_pend = 1'b0;

    // Timeout on an IF read, then a normal data read, then ack in the timeout cycle.
    if_pend = 1'b1; if_addr = 32'h300;
    run_round(0, 1'b1, 1'b0, 32'hFFFFFFFF, won);
    dm_pend = 1'b1; dm_we = 1'b0; dm_addr = 32'h304;
    run_round(0, 1'b0, 1'b0, 32'hCAFEF00D, won);
    dm_pend = 1'b1; dm_we = 1'b0; dm_addr = 32'h308;
    run_round(TO_CYC - 1, 1'b0, 1'b0, 32'h0BADCAFE, won);

    // Delayed ack: memory-side signals must hold for all wait cycles.
    dm_pend = 1'b1; dm_we = 1'b1; dm_addr = 32'h50C; dm_wdata = $urandom;
    run_round(7, 1'b0, 1'b0, $urandom, won);

    // Randomized rounds including requesters dropping their request mid-access.
    for (int r = 0; r < 40; r++) begin
      if (!if_pend) begin if_pend = 1'($urandom_range(0, 1)); if_addr = $urandom; end
      if (!dm_pend) begin
        dm_pend = 1'($urandom_range(0, 1)); dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      if (!if_pend && !dm_pend) dm_pend = 1'b1;
      run_round(int'($urandom_range(0, 5)), 1'b0, ($urandom_range(0, 3) == 0), $urandom, won);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
